// File: rtl/p20_pkg.sv
// p20_pkg: shared constants for the p20_scroll game flow.
//   - FSM state encodings (IDLE/START/RUN/CRASH/OVER), 3 bits wide
//   - speed scheduling and level constants used by p20_scroll_ctrl
package p20_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_CRASH = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [23:0] INITIAL_SPEED = 24'd250000;

  localparam logic [7:0]  MOVE_INIT    = 8'd1;
  localparam logic [7:0]  MOVE_MAX     = 8'd8;
  localparam logic [12:0] LEVEL_DIST   = 13'd1024;
  localparam logic [7:0]  SPEED_DEC    = 8'd16;
  localparam logic [23:0] SPEED_FLOOR  = 24'd50000;
  localparam logic [5:0]  CRASH_FRAMES = 6'd60;

endpackage

// File: rtl/p20_btn_edge.sv
// p20_btn_edge: two-flop synchroniser for an asynchronous button followed by
// a registered rising-edge detector. o_press is a one-cycle pulse that rises
// three clock edges after the button input rises.
// Ports:
//   i_clk   in  clock
//   i_rst   in  synchronous active-high reset
//   i_btn   in  raw asynchronous button, active-high
//   o_press out one-cycle press pulse
module p20_btn_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_q;
  logic r_press;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_q <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_sync2_q <= r_sync2;
      r_press   <= r_sync2 & ~r_sync2_q;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/p20_scroll_ctrl.sv
// p20_scroll_ctrl: game-flow controller and speed scheduler for p20_scroll.
// Sequences IDLE -> START -> RUN -> CRASH -> OVER, drives the scroll unit's
// game reset and halt, schedules pixels-per-tick and tick shortening, and
// keeps the score and best score.
// Ports:
//   i_clk          in   system clock
//   i_sys_rst      in   synchronous active-high reset
//   i_btn          in   raw start/jump button (asynchronous)
//   i_collision    in   dino/cactus overlap level
//   i_frame_tick   in   one-cycle pulse per video frame
//   i_pos[10:0]    in   scroll position from p20_scroll
//   i_speed[23:0]  in   current tick_time from p20_scroll
//   o_game_rst     out  one-cycle reset pulse for a new game (the START cycle)
//   o_halt         out  freezes p20_scroll whenever not in RUN
//   o_move_amt     out  pixels per scroll tick
//   o_speed_change out  tick_time decrement per scroll tick
//   o_score        out  ticks survived this game, saturating
//   o_hi_score     out  best score since reset
//   o_state        out  current FSM state
module p20_scroll_ctrl
  import p20_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_sys_rst,
  input  logic        i_btn,
  input  logic        i_collision,
  input  logic        i_frame_tick,
  input  logic [10:0] i_pos,
  input  logic [23:0] i_speed,
  output logic        o_game_rst,
  output logic        o_halt,
  output logic [7:0]  o_move_amt,
  output logic [7:0]  o_speed_change,
  output logic [15:0] o_score,
  output logic [15:0] o_hi_score,
  output logic [2:0]  o_state
);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic        r_game_rst;
  logic        r_halt;
  logic [7:0]  r_move_amt;
  logic [7:0]  r_speed_change;
  logic [15:0] r_score;
  logic [15:0] r_hi_score;
  logic [11:0] r_dist;
  logic [5:0]  r_crash_ctr;
  logic [10:0] r_pos_q;
  logic        r_after_start;

  logic        w_press;
  logic        w_tick;
  logic [12:0] w_dist_sum;
  logic [12:0] w_dist_wrap;

  p20_btn_edge u_btn_edge (
    .i_clk   (i_clk),
    .i_rst   (i_sys_rst),
    .i_btn   (i_btn),
    .o_press (w_press)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_press) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_RUN;
      ST_RUN:   if (i_collision) w_state_nxt = ST_CRASH;
      ST_CRASH: if (i_frame_tick && (r_crash_ctr == CRASH_FRAMES - 6'd1)) w_state_nxt = ST_OVER;
      ST_OVER:  if (w_press) w_state_nxt = ST_START;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // The first RUN cycle still sees the position jump caused by game_rst,
  // so it is excluded. A same-cycle collision wins over the tick.
  assign w_tick = (r_state == ST_RUN) && !r_after_start &&
                  (i_pos != r_pos_q) && !i_collision;

  assign w_dist_sum  = {1'b0, r_dist} + {5'b0, r_move_amt};
  assign w_dist_wrap = w_dist_sum - LEVEL_DIST;

  always_ff @(posedge i_clk) begin
    if (i_sys_rst) begin
      r_state        <= ST_IDLE;
      r_game_rst     <= 1'b0;
      r_halt         <= 1'b1;
      r_move_amt     <= MOVE_INIT;
      r_speed_change <= 8'd0;
      r_score        <= 16'd0;
      r_hi_score     <= 16'd0;
      r_dist         <= 12'd0;
      r_crash_ctr    <= 6'd0;
      r_pos_q        <= 11'd0;
      r_after_start  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pos_q       <= i_pos;
      r_after_start <= (r_state == ST_START);
      // Outputs are registered from the next state so they line up with it.
      r_game_rst    <= (w_state_nxt == ST_START);
      r_halt        <= (w_state_nxt != ST_RUN);

      // Only shorten the tick while a full step still lands on/above the floor.
      r_speed_change <= ((r_state == ST_RUN) && (i_speed >= SPEED_FLOOR + {16'd0, SPEED_DEC}))
                        ? SPEED_DEC : 8'd0;

      if (r_state == ST_START) begin
        r_score    <= 16'd0;
        r_dist     <= 12'd0;
        r_move_amt <= MOVE_INIT;
      end else if (w_tick) begin
        r_score <= (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
        if (w_dist_sum >= LEVEL_DIST) begin
          r_dist     <= w_dist_wrap[11:0];
          r_move_amt <= (r_move_amt >= MOVE_MAX) ? MOVE_MAX : r_move_amt + 8'd1;
        end else begin
          r_dist <= w_dist_sum[11:0];
        end
      end

      if ((r_state == ST_RUN) && (w_state_nxt == ST_CRASH) && (r_score > r_hi_score))
        r_hi_score <= r_score;

      if (r_state != ST_CRASH)
        r_crash_ctr <= 6'd0;
      else if (i_frame_tick)
        r_crash_ctr <= (r_crash_ctr == CRASH_FRAMES - 6'd1) ? 6'd0 : r_crash_ctr + 6'd1;
    end
  end

  assign o_game_rst     = r_game_rst;
  assign o_halt         = r_halt;
  assign o_move_amt     = r_move_amt;
  assign o_speed_change = r_speed_change;
  assign o_score        = r_score;
  assign o_hi_score     = r_hi_score;
  assign o_state        = r_state;

endmodule
